// File: rtl/stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : stream_serializer
//  Purpose  : Width-down converter. Accepts wide words of up to RATIO beats on
//             a valid/ready input stream and emits them one WIDTH-bit beat at a
//             time on a valid/ready output stream. The final beat of each word
//             is flagged with out_last. The next word is accepted on the edge
//             the current word's last beat is consumed, so words stream
//             back-to-back without bubbles.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             in_data/in_len            - input word and (beat count - 1)
//             in_valid/in_ready         - input handshake
//             out_data/out_last         - current beat and end-of-word flag
//             out_valid/out_ready       - output handshake
//  Options  : STREAM_SERIALIZER_MSB_FIRST_EN - when defined, beats are taken
//             from the most significant slice downward instead of LSB first.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_serializer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH*RATIO-1:0]     in_data,
    input  logic [$clog2(RATIO)-1:0]   in_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int               LW      = $clog2(RATIO);
    localparam logic [LW-1:0]    MAX_IDX = LW'(RATIO - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH*RATIO-1:0]   word_q,  word_d;
    logic [LW-1:0]            idx_q,   idx_d;
    logic [LW-1:0]            lim_q,   lim_d;

    logic                     in_xfer_w;
    logic                     out_xfer_w;
    logic [LW-1:0]            len_clamp_w;
    logic [LW-1:0]            sel_w;

    // Outputs come only from registered state; no path from in_* to out_*.
    assign out_valid  = (state_q == BUSY);
    assign out_last   = out_valid && (idx_q == lim_q);
    assign out_xfer_w = out_valid && out_ready;

    // Ready when empty, or when the last beat leaves on this very edge.
    assign in_ready   = !rst && ((state_q == IDLE) || (out_xfer_w && out_last));
    assign in_xfer_w  = in_valid && in_ready;

    // Compare in 32-bit arithmetic so the clamp stays meaningful (and lint
    // clean) whether or not RATIO is a power of two.
    assign len_clamp_w = (int'(in_len) > RATIO - 1) ? MAX_IDX : in_len;

`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    assign sel_w = MAX_IDX - idx_q;
`else
    assign sel_w = idx_q;
`endif

    assign out_data = word_q[int'(sel_w)*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        lim_d   = lim_q;
        case (state_q)
            IDLE: begin
                if (in_xfer_w) begin
                    state_d = BUSY;
                    word_d  = in_data;
                    idx_d   = '0;
                    lim_d   = len_clamp_w;
                end
            end
            BUSY: begin
                if (out_xfer_w) begin
                    if (!out_last) begin
                        idx_d = idx_q + LW'(1);
                    end else if (in_xfer_w) begin
                        word_d = in_data;
                        idx_d  = '0;
                        lim_d  = len_clamp_w;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            lim_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            lim_q   <= lim_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_serializer
//  Purpose  : Self-checking bench for stream_serializer (WIDTH=8, RATIO=4).
//             Directed scenarios followed by random traffic, all compared
//             against a beat-queue reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_serializer;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [WIDTH*RATIO-1:0]   in_data;
    logic [1:0]               in_len;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready;

    int total = 0;
    int bad   = 0;

    // Reference model: the beats still owed for the word being emitted.
    logic [7:0] q_data[$];
    bit         q_last[$];
    bit         after_rst;

    stream_serializer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expand one accepted word into its beats from the spec's rules.
    task automatic push_word(input logic [31:0] word, input int len);
        int n;
        int slice;
        n = (len > RATIO - 1 ? RATIO - 1 : len) + 1;
        for (int k = 0; k < n; k++) begin
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
            slice = RATIO - 1 - k;
`else
            slice = k;
`endif
            q_data.push_back(8'((word >> (slice * WIDTH)) & 32'hFF));
            q_last.push_back(k == n - 1);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, update model.
    task automatic step(input bit r, input bit v, input logic [31:0] d,
                        input int l, input bit rdy);
        bit exp_rdy;
        bit exp_vld;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        in_len    = 2'(l);
        out_ready = rdy;
        #1;
        exp_vld = (q_data.size() != 0);
        exp_rdy = !r && (q_data.size() == 0 || (rdy && q_data.size() == 1));
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(exp_vld));
        if (exp_vld) begin
            check("out_data", 32'(out_data), 32'(q_data[0]));
            check("out_last", 32'(out_last), 32'(q_last[0]));
        end else if (after_rst) begin
            check("rst_data", 32'(out_data), 32'h0);
            check("rst_last", 32'(out_last), 32'h0);
        end
        @(posedge clk);
        if (r) begin
            q_data.delete();
            q_last.delete();
            after_rst = 1'b1;
        end else begin
            if (exp_vld && rdy) begin
                void'(q_data.pop_front());
                void'(q_last.pop_front());
            end
            if (v && exp_rdy) begin
                push_word(d, l);
                after_rst = 1'b0;
            end
        end
    endtask

    initial begin
        bit bp[7];
        rst = 1'b1; in_valid = 1'b1; in_data = '0; in_len = '0; out_ready = 1'b0;
        after_rst = 1'b1;
        // Settle register state before checking anything.
        repeat (2) @(posedge clk);

        // Reset held with in_valid asserted.
        repeat (3) step(1, 1, 32'h12345678, 3, 1);

        // Full word.
        step(0, 1, 32'h44332211, 3, 1);
        repeat (4) step(0, 0, 32'h0, 0, 1);

        // Back-to-back words with in_valid held for the second.
        step(0, 1, 32'h44332211, 3, 1);
        repeat (4) step(0, 1, 32'h88776655, 3, 1);
        repeat (4) step(0, 0, 32'h0, 0, 1);

        // Backpressure.
        bp = '{1, 0, 0, 1, 0, 1, 1};
        step(0, 1, 32'h44332211, 3, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 32'h0, 0, bp[i]);
        step(0, 0, 32'h0, 0, 1);

        // Partial words.
        step(0, 1, 32'hAABBCC11, 0, 1);
        step(0, 1, 32'hAABB2211, 1, 1);
        repeat (3) step(0, 0, 32'h0, 0, 1);

        // Single-beat words every cycle.
        for (int i = 0; i < 4; i++) step(0, 1, 32'h0 + i * 32'h01010101, 0, 1);
        step(0, 0, 32'h0, 0, 1);

        // Reset mid-word, then a fresh word.
        step(0, 1, 32'h44332211, 3, 1);
        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 1);
        step(1, 0, 32'h0, 0, 1);
        step(0, 1, 32'hDDCCBBAA, 3, 1);
        repeat (5) step(0, 0, 32'h0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 70),
                 $urandom,
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 70));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
